// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link responder: frame FSM states and byte width.
package serial_link_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_IDX_W = $clog2(BYTE_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_LOW
    } state_t;

endpackage

// File: rtl/serial_rx_fifo.sv
// Receive byte FIFO; a pop in the same cycle frees the slot for a push into a full FIFO.
module serial_rx_fifo
    import serial_link_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_push,
    input  logic [BYTE_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [BYTE_W-1:0] o_pop_data,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push && (!o_full || w_do_pop);
    assign o_drop     = i_push && !w_do_push;

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/serial_responder.sv
// Serial link responder: shifts one byte each way per 8-cycle frame, with a one-entry
// tx holding register and a receive FIFO towards the host.
module serial_responder
    import serial_link_pkg::*;
#(
    parameter int RX_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              link_sel,
    input  logic              link_in,
    output logic              link_out,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun,
    output logic              underrun,
    output logic              frame_err
);

    state_t                r_state;
    state_t                w_next_state;
    logic [BIT_IDX_W-1:0]  r_bit_idx;
    logic [BYTE_W-1:0]     r_rx_shift;
    logic [BYTE_W-1:0]     r_tx_shift;
    logic [BYTE_W-1:0]     r_hold_data;
    logic                  r_hold_full;
    logic                  r_overrun;
    logic                  r_underrun;
    logic                  r_frame_err;

    logic                  w_start;
    logic                  w_capture;
    logic                  w_last;
    logic                  w_abort;
    logic                  w_tx_xfer;
    logic [BYTE_W-1:0]     w_push_data;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_fifo_drop;

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (link_sel) w_next_state = SHIFT;
            SHIFT: begin
                if (!link_sel)                               w_next_state = IDLE;
                else if (r_bit_idx == BIT_IDX_W'(BYTE_W - 1)) w_next_state = WAIT_LOW;
            end
            WAIT_LOW: if (!link_sel) w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_comb begin
        link_out    = 1'b0;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                link_out = r_hold_full & r_hold_data[0];
                w_start  = link_sel;
            end
            SHIFT: begin
                link_out  = r_tx_shift[r_bit_idx];
                w_capture = link_sel;
                w_abort   = !link_sel;
            end
            default: link_out = 1'b0;
        endcase
        w_last      = w_capture && (r_bit_idx == BIT_IDX_W'(BYTE_W - 1));
        w_push_data = {link_in, r_rx_shift[BYTE_W-2:0]};
        w_tx_xfer   = tx_valid && !r_hold_full;
    end

    // A host transfer into an empty hold during the bit-0 cycle refills the hold for the
    // next frame; the current frame has already latched the empty (zero) byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bit_idx   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_hold_data <= '0;
            r_hold_full <= 1'b0;
            r_overrun   <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_tx_xfer) begin
                r_hold_full <= 1'b1;
                r_hold_data <= tx_data;
            end else if (w_start) begin
                r_hold_full <= 1'b0;
            end

            if (w_start) begin
                r_rx_shift <= BYTE_W'(link_in);
                r_tx_shift <= r_hold_full ? r_hold_data : '0;
                r_bit_idx  <= BIT_IDX_W'(1);
            end else if (w_capture) begin
                r_rx_shift[r_bit_idx] <= link_in;
                r_bit_idx             <= w_last ? '0 : r_bit_idx + BIT_IDX_W'(1);
            end else if (w_abort) begin
                r_bit_idx <= '0;
            end

            r_underrun  <= w_start && !r_hold_full;
            r_frame_err <= w_abort;
            r_overrun   <= w_fifo_drop;
        end
    end

    serial_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_last),
        .i_push_data (w_push_data),
        .i_pop       (rx_ready),
        .o_pop_data  (rx_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_drop      (w_fifo_drop)
    );

    assign tx_ready  = !r_hold_full;
    assign rx_valid  = !w_fifo_empty;
    assign overrun   = r_overrun;
    assign underrun  = r_underrun;
    assign frame_err = r_frame_err;

    // Full state is only needed inside the FIFO for drop decisions.
    logic w_unused;
    assign w_unused = w_fifo_full;

endmodule

// File: tb/tb_serial_responder.sv
// Bench for serial_responder: directed frame scenarios plus randomized frames against a queue model.
module tb_serial_responder;

    localparam int RX_DEPTH = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       link_sel = 1'b0;
    logic       link_in = 1'b0;
    logic       link_out;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       overrun;
    logic       underrun;
    logic       frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_und    = 0;
    int n_ovr    = 0;
    int n_ferr   = 0;

    serial_responder #(
        .RX_DEPTH (RX_DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .link_sel  (link_sel),
        .link_in   (link_in),
        .link_out  (link_out),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .overrun   (overrun),
        .underrun  (underrun),
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;

    // Count high cycles of each event pulse; a pulse wider than one cycle shows up as an extra count.
    always @(posedge clock) begin
        if (underrun)  n_und++;
        if (overrun)   n_ovr++;
        if (frame_err) n_ferr++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic load_tx(input logic [7:0] b);
        @(negedge clock);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    // Drive ncyc cycles of link_sel high (bits beyond 8 random), record link_out per bit,
    // optionally pop during the final bit cycle, then leave link_sel low for three cycles.
    task automatic run_frame(input logic [7:0] b, input int ncyc, input bit pop_last,
                             output logic [7:0] lo, output logic [7:0] popped);
        lo     = '0;
        popped = '0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clock);
            link_sel = 1'b1;
            link_in  = (i < 8) ? b[i] : 1'($urandom);
            rx_ready = pop_last && (i == 7);
            #1;
            if (i < 8) lo[i] = link_out;
            if (pop_last && i == 7) popped = rx_data;
        end
        @(negedge clock);
        link_sel = 1'b0;
        link_in  = 1'b0;
        rx_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic pop_byte(output logic [7:0] d, output logic v);
        @(negedge clock);
        v        = rx_valid;
        d        = rx_data;
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++; if (link_out !== 1'b0)  $display("FAIL rst_link_out: got %b want 0", link_out);   else n_pass++;
        n_checks++; if (tx_ready !== 1'b1)  $display("FAIL rst_tx_ready: got %b want 1", tx_ready);   else n_pass++;
        n_checks++; if (rx_valid !== 1'b0)  $display("FAIL rst_rx_valid: got %b want 0", rx_valid);   else n_pass++;
        n_checks++; if ({overrun, underrun, frame_err} !== 3'b000)
            $display("FAIL rst_pulses: got %b want 000", {overrun, underrun, frame_err}); else n_pass++;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic;
        logic [7:0] lo, pp, d;
        logic v;
        int u0;
        load_tx(8'hA5);
        n_checks++; if (tx_ready !== 1'b0) $display("FAIL basic_hold_full: tx_ready got %b want 0", tx_ready); else n_pass++;
        n_checks++; if (link_out !== 1'b1) $display("FAIL basic_idle_out: got %b want 1", link_out); else n_pass++;
        u0 = n_und;
        run_frame(8'h3C, 8, 1'b0, lo, pp);
        n_checks++; if (lo !== 8'hA5) $display("FAIL basic_link_out: got %h want a5", lo); else n_pass++;
        n_checks++; if (n_und - u0 !== 0) $display("FAIL basic_underrun: got %0d want 0", n_und - u0); else n_pass++;
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL basic_tx_ready: got %b want 1", tx_ready); else n_pass++;
        n_checks++; if (link_out !== 1'b0) $display("FAIL basic_idle_empty: got %b want 0", link_out); else n_pass++;
        pop_byte(d, v);
        n_checks++; if ({v, d} !== {1'b1, 8'h3C}) $display("FAIL basic_rx: got %b/%h want 1/3c", v, d); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL basic_drained: got %b want 0", rx_valid); else n_pass++;
    endtask

    task automatic test_underrun;
        logic [7:0] lo, pp, d;
        logic v;
        int u0;
        u0 = n_und;
        run_frame(8'h81, 8, 1'b0, lo, pp);
        n_checks++; if (lo !== 8'h00) $display("FAIL und_link_out: got %h want 00", lo); else n_pass++;
        n_checks++; if (n_und - u0 !== 1) $display("FAIL und_pulse: got %0d want 1", n_und - u0); else n_pass++;
        pop_byte(d, v);
        n_checks++; if ({v, d} !== {1'b1, 8'h81}) $display("FAIL und_rx: got %b/%h want 1/81", v, d); else n_pass++;
    endtask

    task automatic test_overrun;
        logic [7:0] lo, pp, d;
        logic v;
        int o0;
        o0 = n_ovr;
        run_frame(8'h11, 8, 1'b0, lo, pp);
        run_frame(8'h22, 8, 1'b0, lo, pp);
        n_checks++; if (n_ovr - o0 !== 0) $display("FAIL ovr_early: got %0d want 0", n_ovr - o0); else n_pass++;
        run_frame(8'h33, 8, 1'b0, lo, pp);
        n_checks++; if (n_ovr - o0 !== 1) $display("FAIL ovr_pulse: got %0d want 1", n_ovr - o0); else n_pass++;
        pop_byte(d, v);
        n_checks++; if ({v, d} !== {1'b1, 8'h11}) $display("FAIL ovr_pop1: got %b/%h want 1/11", v, d); else n_pass++;
        pop_byte(d, v);
        n_checks++; if ({v, d} !== {1'b1, 8'h22}) $display("FAIL ovr_pop2: got %b/%h want 1/22", v, d); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL ovr_drained: got %b want 0", rx_valid); else n_pass++;
    endtask

    task automatic test_short_frame;
        logic [7:0] lo, pp, d;
        logic v;
        int f0, u0;
        load_tx(8'hC3);
        f0 = n_ferr;
        run_frame(8'($urandom), 5, 1'b0, lo, pp);
        n_checks++; if (n_ferr - f0 !== 1) $display("FAIL short_ferr: got %0d want 1", n_ferr - f0); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL short_no_push: got %b want 0", rx_valid); else n_pass++;
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL short_tx_consumed: got %b want 1", tx_ready); else n_pass++;
        u0 = n_und;
        f0 = n_ferr;
        run_frame(8'h5A, 8, 1'b0, lo, pp);
        n_checks++; if (lo !== 8'h00) $display("FAIL short_not_restored: got %h want 00", lo); else n_pass++;
        n_checks++; if (n_und - u0 !== 1) $display("FAIL short_next_und: got %0d want 1", n_und - u0); else n_pass++;
        n_checks++; if (n_ferr - f0 !== 0) $display("FAIL short_next_ferr: got %0d want 0", n_ferr - f0); else n_pass++;
        pop_byte(d, v);
        n_checks++; if ({v, d} !== {1'b1, 8'h5A}) $display("FAIL short_rx: got %b/%h want 1/5a", v, d); else n_pass++;
    endtask

    task automatic test_long_frame;
        logic [7:0] lo, pp, d;
        logic v;
        run_frame(8'hF0, 12, 1'b0, lo, pp);
        pop_byte(d, v);
        n_checks++; if ({v, d} !== {1'b1, 8'hF0}) $display("FAIL long_rx: got %b/%h want 1/f0", v, d); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL long_single: got %b want 0", rx_valid); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] lo, pp, d, a, b, c;
        logic v;
        int o0;
        a = 8'($urandom);
        b = 8'($urandom);
        c = 8'($urandom);
        o0 = n_ovr;
        run_frame(a, 8, 1'b0, lo, pp);
        run_frame(b, 8, 1'b0, lo, pp);
        run_frame(c, 8, 1'b1, lo, pp);
        n_checks++; if (pp !== a) $display("FAIL b2b_pop_head: got %h want %h", pp, a); else n_pass++;
        n_checks++; if (n_ovr - o0 !== 0) $display("FAIL b2b_no_ovr: got %0d want 0", n_ovr - o0); else n_pass++;
        pop_byte(d, v);
        n_checks++; if ({v, d} !== {1'b1, b}) $display("FAIL b2b_pop2: got %b/%h want 1/%h", v, d, b); else n_pass++;
        pop_byte(d, v);
        n_checks++; if ({v, d} !== {1'b1, c}) $display("FAIL b2b_pop3: got %b/%h want 1/%h", v, d, c); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL b2b_drained: got %b want 0", rx_valid); else n_pass++;
    endtask

    task automatic test_reset_midframe;
        logic [7:0] lo, pp, d;
        logic v;
        int f0, u0;
        load_tx(8'hFF);
        f0 = n_ferr;
        u0 = n_und;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            link_sel = 1'b1;
            link_in  = 1'($urandom);
        end
        @(negedge clock);
        link_in = 1'b1;
        reset   = 1'b1;
        @(negedge clock);
        n_checks++; if (link_out !== 1'b0) $display("FAIL mid_link_out: got %b want 0", link_out); else n_pass++;
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL mid_tx_ready: got %b want 1", tx_ready); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL mid_rx_valid: got %b want 0", rx_valid); else n_pass++;
        n_checks++; if ({overrun, underrun, frame_err} !== 3'b000)
            $display("FAIL mid_pulses: got %b want 000", {overrun, underrun, frame_err}); else n_pass++;
        reset    = 1'b0;
        link_sel = 1'b0;
        link_in  = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if (n_ferr - f0 !== 0) $display("FAIL mid_ferr: got %0d want 0", n_ferr - f0); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL mid_no_push: got %b want 0", rx_valid); else n_pass++;
        run_frame(8'h77, 8, 1'b0, lo, pp);
        n_checks++; if (lo !== 8'h00) $display("FAIL mid_hold_cleared: got %h want 00", lo); else n_pass++;
        n_checks++; if (n_und - u0 !== 1) $display("FAIL mid_underrun: got %0d want 1", n_und - u0); else n_pass++;
        pop_byte(d, v);
        n_checks++; if ({v, d} !== {1'b1, 8'h77}) $display("FAIL mid_rx: got %b/%h want 1/77", v, d); else n_pass++;
    endtask

    // Reference: each frame returns the held byte (or zero with one underrun) and appends the
    // received byte to a bounded queue, dropping it with one overrun when the queue is full.
    task automatic test_random;
        logic [7:0] q[$];
        logic [7:0] lo, pp, d, txb, rb, exp_lo, exp_d;
        logic v;
        bit have_tx, exp_ovr;
        int u0, o0, len;
        for (int it = 0; it < 40; it++) begin
            have_tx = 1'($urandom_range(0, 1));
            txb     = 8'($urandom);
            rb      = 8'($urandom);
            len     = $urandom_range(8, 10);
            if (have_tx) load_tx(txb);
            exp_lo  = have_tx ? txb : 8'h00;
            exp_ovr = (q.size() >= RX_DEPTH);
            u0 = n_und;
            o0 = n_ovr;
            run_frame(rb, len, 1'b0, lo, pp);
            if (!exp_ovr) q.push_back(rb);
            n_checks++; if (lo !== exp_lo) $display("FAIL rnd_link_out[%0d]: got %h want %h", it, lo, exp_lo); else n_pass++;
            n_checks++; if (n_und - u0 !== int'(!have_tx)) $display("FAIL rnd_underrun[%0d]: got %0d want %0d", it, n_und - u0, int'(!have_tx)); else n_pass++;
            n_checks++; if (n_ovr - o0 !== int'(exp_ovr)) $display("FAIL rnd_overrun[%0d]: got %0d want %0d", it, n_ovr - o0, int'(exp_ovr)); else n_pass++;
            n_checks++; if (rx_valid !== (q.size() != 0)) $display("FAIL rnd_rx_valid[%0d]: got %b want %b", it, rx_valid, q.size() != 0); else n_pass++;
            if ($urandom_range(0, 2) != 0 && q.size() != 0) begin
                exp_d = q.pop_front();
                pop_byte(d, v);
                n_checks++; if ({v, d} !== {1'b1, exp_d}) $display("FAIL rnd_pop[%0d]: got %b/%h want 1/%h", it, v, d, exp_d); else n_pass++;
            end
        end
        while (q.size() != 0) begin
            exp_d = q.pop_front();
            pop_byte(d, v);
            n_checks++; if ({v, d} !== {1'b1, exp_d}) $display("FAIL rnd_drain: got %b/%h want 1/%h", v, d, exp_d); else n_pass++;
        end
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL rnd_empty: got %b want 0", rx_valid); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_underrun;
        test_overrun;
        test_short_frame;
        test_long_frame;
        test_back_to_back;
        test_reset_midframe;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_responder.md
SERIAL_RESPONDER -- requirements
Module: serial_responder

Interface
REQ-001 Parameter: RX_DEPTH, default 2, receive FIFO depth in bytes (power of two, 2..8).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 link_sel  input  1  frame select from link initiator; high for exactly 8 cycles per frame.
REQ-005 link_in  input  1  initiator-to-responder data bit, LSB first, valid at each rising edge while link_sel high.
REQ-006 link_out  output  1  responder-to-initiator data bit, LSB first, combinational from state/registers.
REQ-007 tx_data  input  8  response byte from host.
REQ-008 tx_valid / tx_ready  input / output  1 each  host-to-responder handshake; transfer when both high at rising edge.
REQ-009 rx_data  output  8  head of receive FIFO.
REQ-010 rx_valid / rx_ready  output / input  1 each  responder-to-host handshake; pop when both high at rising edge.
REQ-011 overrun, underrun, frame_err  output  1 each  single-cycle event pulses.

Function
REQ-012 States SHALL be IDLE, SHIFT, WAIT_LOW.
REQ-013 One-entry tx holding register; tx_ready SHALL equal NOT hold_full; host transfer sets hold_full and captures tx_data.
REQ-014 IDLE: link_out SHALL be hold_data[0] if hold_full, else 0.
REQ-015 IDLE with link_sel=1: bit 0 cycle; capture link_in into rx_shift[0]; load tx_shift from hold_data (clear hold_full) or 0x00 with underrun=1 if empty; bit_idx<=1; go SHIFT.
REQ-016 SHIFT: link_out SHALL be tx_shift[bit_idx]; each cycle with link_sel=1 capture link_in into rx_shift[bit_idx], bit_idx increments.
REQ-017 SHIFT at bit_idx=7 with link_sel=1: capture bit 7, push completed byte into FIFO, go WAIT_LOW.
REQ-018 SHIFT with link_sel=0 (frame shorter than 8): discard partial byte, frame_err=1 for one cycle, go IDLE; tx byte consumed, not restored.
REQ-019 WAIT_LOW: link_out SHALL be 0; link_sel=1 ignored (no capture); link_sel=0 -> IDLE. Minimum one low cycle between frames.
REQ-020 Push into full FIFO: byte dropped, overrun=1 for one cycle, FIFO contents unchanged.
REQ-021 Simultaneous push and pop on full FIFO SHALL succeed (pop frees slot same cycle), no overrun.
REQ-022 rx_valid SHALL be high iff FIFO non-empty; rx_data stable while rx_valid high and no pop.
REQ-023 Host tx transfer in the same cycle hold is loaded into tx_shift: not possible since tx_ready=0 when full; a transfer into empty hold in the REQ-015 cycle SHALL not affect the current frame (underrun still pulses).
REQ-024 FIFO pointers SHALL wrap modulo RX_DEPTH; occupancy count width clog2(RX_DEPTH)+1.

Reset
REQ-025 Reset SHALL force: state IDLE, bit_idx 0, hold_full 0, FIFO empty, rx_shift/tx_shift 0, link_out 0, tx_ready 1, rx_valid 0, overrun/underrun/frame_err 0.
REQ-026 Reset mid-frame SHALL abort without frame_err; next frame starts only after reset deasserted and link_sel sampled in IDLE.

Structure
REQ-027 State enum and BYTE_W=8 constant SHALL reside in shared package serial_link_pkg.
REQ-028 Receive FIFO SHALL be sub-module serial_rx_fifo (parameterized depth, push/pop/full/empty).

Verification
REQ-029 Load tx 0xA5, send frame 0x3C (link_in bits 0,0,1,1,1,1,0,0) -> link_out bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid next cycle.
REQ-030 Empty hold, send 0x81 -> underrun pulse at bit 0, link_out all 0, rx_data=0x81.
REQ-031 rx_ready=0, send 0x11,0x22,0x33 (RX_DEPTH=2) -> overrun on third; pops yield 0x11 then 0x22.
REQ-032 Drop link_sel after 5 bits -> frame_err one cycle, FIFO unchanged; following full frame 0x5A received correctly.
REQ-033 link_sel held high 12 cycles sending 0xF0 -> one byte 0xF0 pushed, extra 4 bits ignored.
REQ-034 Assert reset at bit 3 -> all outputs at reset values, no push, no frame_err; subsequent frame 0x77 received.
